fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_skid_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the instruction fetch unit.
//   XLEN          : architectural address/data width
//   RESET_PC_DEF  : default first fetch address after reset
//   fetch_entry_t : one buffered fetch result {pc, instr}
//   fetch_state_t : fetch control FSM states
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// -----------------------------------------------------------------------------
// fetch_skid_fifo
// Two-entry FIFO holding fetched {pc, instr} pairs between the instruction
// memory and decode. Flush has priority over push/pop. Data storage is not
// reset; only the pointers and the occupancy count are.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   i_push        : write i_push_data this cycle (never while full)
//   i_push_data   : entry to write
//   i_pop         : drop the head entry (only while non-empty)
//   i_flush       : empty the FIFO, overrides push and pop
//   o_count       : current occupancy (0..2)
//   o_head        : oldest entry, meaningful only when o_count != 0
// -----------------------------------------------------------------------------
module fetch_skid_fifo
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  fetch_entry_t i_push_data,
   input  logic         i_pop,
   input  logic         i_flush,
   output logic [1:0]   o_count,
   output fetch_entry_t o_head
);

   fetch_entry_t r_mem [2];
   logic         r_rd_ptr;
   logic         r_wr_ptr;
   logic [1:0]   r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) r_wr_ptr <= ~r_wr_ptr;
         if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   // Payload storage carries no reset; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Sequential instruction fetcher for a synchronous instruction memory with
// one cycle read latency. Keeps at most two instructions buffered or in
// flight, so a returning read always has a free FIFO slot. Redirects restart
// fetch at the new target and drop everything buffered or in flight.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   imem_addr       : fetch address (straight from pc register)
//   imem_rdata      : memory data for the address sampled last cycle
//   redirect_valid  : redirect request, redirect_pc is the target
//   if_valid/ready  : handshake to decode
//   if_pc/if_instr  : presented instruction and its address
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
   parameter int              FIFO_DEPTH = 2    // only 2 is supported
)(
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr
);

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_req_pc;
   logic            r_inflight;

   logic [1:0]      w_count;
   fetch_entry_t    w_head;
   fetch_entry_t    w_push_data;
   logic            w_pop;
   logic [2:0]      w_occ;
   logic            w_issue;

   assign w_pop = if_valid & if_ready;

   // Occupancy after this cycle's push (the in-flight read lands now) and pop.
   // A new request is only issued if its data will have a slot next cycle.
   assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue = !redirect_valid && (w_occ < 3'(FIFO_DEPTH));

   assign w_push_data.pc    = r_req_pc;
   assign w_push_data.instr = imem_rdata;

   // Issue is allowed in BOOT as well so the first fetch leaves on the first
   // edge after reset release. Redirect applies in any state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_BOOT;
         r_pc       <= RESET_PC;
         r_req_pc   <= RESET_PC;
         r_inflight <= 1'b0;
      end else begin
         case (r_state)
            ST_BOOT: r_state <= ST_RUN;
            ST_RUN:  r_state <= ST_RUN;
            default: r_state <= ST_BOOT;
         endcase

         if (redirect_valid) begin
            r_pc       <= {redirect_pc[XLEN-1:2], 2'b00};
            r_inflight <= 1'b0;
         end else if (w_issue) begin
            r_inflight <= 1'b1;
            r_req_pc   <= r_pc;
            r_pc       <= r_pc + 32'd4;
         end else begin
            r_inflight <= 1'b0;
         end
      end
   end

   fetch_skid_fifo u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (r_inflight),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .i_flush     (redirect_valid),
      .o_count     (w_count),
      .o_head      (w_head)
   );

   assign imem_addr = r_pc;
   assign if_valid  = (w_count != 2'd0);
   assign if_pc     = w_head.pc;
   assign if_instr  = w_head.instr;

endmodule
